// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen geometry, VRAM sizing and swap FSM encoding
package vga_pkg;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int BANK_SIZE     = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int PIX_A_WIDTH   = 19;
  localparam int MEM_A_WIDTH   = 20;
  localparam int DATA_WIDTH    = 6;

  typedef enum logic {
    RUN       = 1'b0,
    SWAP_PEND = 1'b1
  } swap_state_t;
endpackage

// File: rtl/bank_swap_fsm.sv
// rtl/bank_swap_fsm.sv - front/back bank swap scheduler, toggles only on frame_stb
module bank_swap_fsm
  import vga_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic frame_stb,
  input  logic swap_req,
  output logic front_bank,
  output logic swap_done
);

  swap_state_t state;
  swap_state_t state_next;
  logic        toggle;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= RUN;
      front_bank <= 1'b0;
      swap_done  <= 1'b0;
    end else begin
      state      <= state_next;
      front_bank <= front_bank ^ toggle;
      swap_done  <= toggle;
    end
  end

  // A strobe coinciding with the request in RUN is deliberately not used:
  // the swap waits for the next full frame boundary.
  always_comb begin
    state_next = state;
    toggle     = 1'b0;
    case (state)
      RUN: begin
        if (swap_req) state_next = SWAP_PEND;
      end
      SWAP_PEND: begin
        if (frame_stb) begin
          toggle     = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: rtl/vram_bank_arbiter.sv
// rtl/vram_bank_arbiter.sv - display-first arbiter over a double-buffered single-port VRAM
module vram_bank_arbiter #(
  parameter int PIX_A_WIDTH = vga_pkg::PIX_A_WIDTH,
  parameter int MEM_A_WIDTH = vga_pkg::MEM_A_WIDTH,
  parameter int DATA_WIDTH  = vga_pkg::DATA_WIDTH,
  parameter int BANK_SIZE   = vga_pkg::BANK_SIZE
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   frame_stb,
  input  logic                   rd_req,
  input  logic [PIX_A_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  input  logic                   wr_valid,
  input  logic [PIX_A_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_ready,
  output logic                   wr_oob,
  input  logic                   swap_req,
  output logic                   swap_done,
  output logic                   front_bank,
  output logic [MEM_A_WIDTH-1:0] mem_addr,
  output logic                   mem_we,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata
);

  localparam logic [MEM_A_WIDTH-1:0] BANK_BASE = MEM_A_WIDTH'(BANK_SIZE);

  logic [1:0]             rd_pipe;
  logic                   wr_acc;
  logic                   wr_in_range;
  logic [MEM_A_WIDTH-1:0] rd_ext;
  logic [MEM_A_WIDTH-1:0] wr_ext;
  logic [MEM_A_WIDTH-1:0] rd_issue_addr;
  logic [MEM_A_WIDTH-1:0] wr_issue_addr;

  bank_swap_fsm u_swap_fsm (
    .CLK        (CLK),
    .RST        (RST),
    .frame_stb  (frame_stb),
    .swap_req   (swap_req),
    .front_bank (front_bank),
    .swap_done  (swap_done)
  );

  assign wr_ready = ~RST & ~rd_req;
  assign wr_acc   = wr_valid & wr_ready;
  assign rd_valid = rd_pipe[1];
  assign rd_data  = rd_pipe[1] ? mem_rdata : '0;

  // Out-of-range reads are folded onto the bank base so the display never stalls.
  always_comb begin
    rd_ext        = MEM_A_WIDTH'(rd_addr);
    wr_ext        = MEM_A_WIDTH'(wr_addr);
    wr_in_range   = (wr_ext < BANK_BASE);
    rd_issue_addr = ((rd_ext < BANK_BASE) ? rd_ext : '0) + (front_bank ? BANK_BASE : '0);
    wr_issue_addr = wr_ext + (front_bank ? '0 : BANK_BASE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_pipe   <= 2'b00;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_oob    <= 1'b0;
    end else begin
      rd_pipe <= {rd_pipe[0], rd_req};
      wr_oob  <= wr_acc & ~wr_in_range;
      if (rd_req) begin
        mem_addr <= rd_issue_addr;
        mem_we   <= 1'b0;
      end else if (wr_acc && wr_in_range) begin
        mem_addr  <= wr_issue_addr;
        mem_we    <= 1'b1;
        mem_wdata <= wr_data;
      end else begin
        mem_we <= 1'b0;
      end
    end
  end

endmodule
